biu_axi3_arbiter: RTL and testbench

//  Two-requester arbiter sharing one biu_axi3 bridge between instruction fetch (m0) and data (m1).

---
 rtl/biu_axi3_arbiter.sv | 245 ++++++++++++++++++++++++
 tb/tb_biu_axi3_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_axi3_arbiter.sv
// Two-requester arbiter in front of the single BIU slave port of the biu_axi3 bridge.
// m0 is instruction fetch, m1 is data; the granted requester owns the bridge until its burst ends.

package biu_axi3_pkg;
  typedef logic [2:0] biu_size_t;
  typedef logic [2:0] biu_prot_t;
  typedef enum logic [2:0] {
    BIU_SINGLE = 3'd0,
    BIU_INCR   = 3'd1,
    BIU_WRAP4  = 3'd2,
    BIU_INCR4  = 3'd3,
    BIU_WRAP8  = 3'd4,
    BIU_INCR8  = 3'd5,
    BIU_WRAP16 = 3'd6,
    BIU_INCR16 = 3'd7
  } biu_type_t;
endpackage

// Handshake: a requester raises stb and holds it (with its request fields) until the cycle
// stb_ack is high; that cycle accepts the request. Afterwards each cycle with ack or err high
// completes exactly one beat, and each cycle with d_ack high asks for the next write data word.
module biu_axi3_arbiter
  import biu_axi3_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int ADDR_SIZE = DATA_SIZE,
  parameter int ARB_MODE  = 0
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,

  input  logic                 m0_stb_i,
  output logic                 m0_stb_ack_o,
  output logic                 m0_d_ack_o,
  input  logic [ADDR_SIZE-1:0] m0_adri_i,
  input  biu_size_t            m0_size_i,
  input  biu_type_t            m0_type_i,
  input  biu_prot_t            m0_prot_i,
  input  logic                 m0_lock_i,
  input  logic                 m0_we_i,
  input  logic [DATA_SIZE-1:0] m0_d_i,
  output logic [DATA_SIZE-1:0] m0_q_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,

  input  logic                 m1_stb_i,
  output logic                 m1_stb_ack_o,
  output logic                 m1_d_ack_o,
  input  logic [ADDR_SIZE-1:0] m1_adri_i,
  input  biu_size_t            m1_size_i,
  input  biu_type_t            m1_type_i,
  input  biu_prot_t            m1_prot_i,
  input  logic                 m1_lock_i,
  input  logic                 m1_we_i,
  input  logic [DATA_SIZE-1:0] m1_d_i,
  output logic [DATA_SIZE-1:0] m1_q_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,

  output logic                 s_stb_o,
  input  logic                 s_stb_ack_i,
  input  logic                 s_d_ack_i,
  output logic [ADDR_SIZE-1:0] s_adri_o,
  output biu_size_t            s_size_o,
  output biu_type_t            s_type_o,
  output biu_prot_t            s_prot_o,
  output logic                 s_lock_o,
  output logic                 s_we_o,
  output logic [DATA_SIZE-1:0] s_d_o,
  input  logic [DATA_SIZE-1:0] s_q_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,

  output logic                 arb_owner_o,
  output logic                 arb_busy_o,
  output logic [1:0]           arb_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic       lock_q, lock_d;
  logic [3:0] beat_cnt_q, beat_cnt_d;

  logic                 own_stb;
  logic [ADDR_SIZE-1:0] own_adri;
  biu_size_t            own_size;
  biu_type_t            own_type;
  biu_prot_t            own_prot;
  logic                 own_lock;
  logic                 own_we;
  logic [DATA_SIZE-1:0] own_d;

  logic grant_vld;
  logic grant_id;
  logic fwd_stb_ack;
  logic fwd_ack;
  logic fwd_err;
  logic fwd_d_ack;

  function automatic logic [3:0] last_beat(input biu_type_t t);
    case (t)
      BIU_WRAP4,  BIU_INCR4:  last_beat = 4'd3;
      BIU_WRAP8,  BIU_INCR8:  last_beat = 4'd7;
      BIU_WRAP16, BIU_INCR16: last_beat = 4'd15;
      default:                last_beat = 4'd0;
    endcase
  endfunction

  always_comb begin
    own_stb  = owner_q ? m1_stb_i  : m0_stb_i;
    own_adri = owner_q ? m1_adri_i : m0_adri_i;
    own_size = owner_q ? m1_size_i : m0_size_i;
    own_type = owner_q ? m1_type_i : m0_type_i;
    own_prot = owner_q ? m1_prot_i : m0_prot_i;
    own_lock = owner_q ? m1_lock_i : m0_lock_i;
    own_we   = owner_q ? m1_we_i   : m0_we_i;
    own_d    = owner_q ? m1_d_i    : m0_d_i;
  end

  // A locked sequence pins the bridge to its owner; the other side waits even if the owner is idle.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    if (lock_q) begin
      grant_vld = own_stb;
      grant_id  = owner_q;
    end else if (m0_stb_i && m1_stb_i) begin
      grant_vld = 1'b1;
      grant_id  = (ARB_MODE != 0) ? 1'b1 : ~last_grant_q;
    end else begin
      grant_vld = m0_stb_i | m1_stb_i;
      grant_id  = m1_stb_i;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      lock_q       <= 1'b0;
      beat_cnt_q   <= 4'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      lock_q       <= lock_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    lock_d       = lock_q;
    beat_cnt_d   = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_id;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (s_stb_ack_i) begin
          beat_cnt_d = last_beat(own_type);
          lock_d     = own_lock;
          state_d    = ST_WAIT;
        end else if (!own_stb) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Error beats still count so the bridge and arbiter stay aligned on burst length.
        if (s_ack_i || s_err_i) begin
          if (beat_cnt_q == 4'd0) begin
            state_d      = ST_IDLE;
            last_grant_d = owner_q;
          end else begin
            beat_cnt_d = beat_cnt_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_stb_o     = 1'b0;
    s_adri_o    = '0;
    s_size_o    = '0;
    s_type_o    = BIU_SINGLE;
    s_prot_o    = '0;
    s_lock_o    = 1'b0;
    s_we_o      = 1'b0;
    s_d_o       = '0;
    fwd_stb_ack = 1'b0;
    fwd_ack     = 1'b0;
    fwd_err     = 1'b0;
    fwd_d_ack   = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        s_stb_o     = own_stb;
        s_adri_o    = own_adri;
        s_size_o    = own_size;
        s_type_o    = own_type;
        s_prot_o    = own_prot;
        s_lock_o    = own_lock;
        s_we_o      = own_we;
        fwd_stb_ack = s_stb_ack_i;
      end
      ST_WAIT: begin
        s_d_o     = own_d;
        fwd_ack   = s_ack_i;
        fwd_err   = s_err_i;
        fwd_d_ack = s_d_ack_i;
      end
      default: ;
    endcase
  end

  assign m0_stb_ack_o = fwd_stb_ack & ~owner_q;
  assign m0_ack_o     = fwd_ack     & ~owner_q;
  assign m0_err_o     = fwd_err     & ~owner_q;
  assign m0_d_ack_o   = fwd_d_ack   & ~owner_q;
  assign m1_stb_ack_o = fwd_stb_ack &  owner_q;
  assign m1_ack_o     = fwd_ack     &  owner_q;
  assign m1_err_o     = fwd_err     &  owner_q;
  assign m1_d_ack_o   = fwd_d_ack   &  owner_q;

  assign m0_q_o      = s_q_i;
  assign m1_q_o      = s_q_i;
  assign arb_owner_o = owner_q;
  assign arb_busy_o  = (state_q != ST_IDLE);
  assign arb_state_o = state_q;

endmodule

// File: tb/tb_biu_axi3_arbiter.sv
// Bench for biu_axi3_arbiter: one round-robin and one fixed-priority instance on shared stimulus,
// cycle-by-cycle vector table plus a hand sequence for request-field forwarding.
module tb_biu_axi3_arbiter;
  import biu_axi3_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;

  // clock / reset
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          m0_stb = 0, m1_stb = 0, m0_lock = 0, m1_lock = 0, m0_we = 0, m1_we = 1;
  logic [AW-1:0] m0_adri = 32'h1000_0010, m1_adri = 32'h2000_0040;
  logic [DW-1:0] m0_d = 32'h0a0a_0a0a, m1_d = 32'h5050_5050, s_q = 32'hdead_beef;
  biu_size_t     m0_size = 3'd2, m1_size = 3'd1;
  biu_prot_t     m0_prot = 3'd2, m1_prot = 3'd5;
  biu_type_t     m0_type = BIU_SINGLE, m1_type = BIU_SINGLE;
  logic          s_stb_ack = 0, s_d_ack = 0, s_ack = 0, s_err = 0;

  logic          rr_m0_sa, rr_m0_da, rr_m0_ack, rr_m0_err, rr_m1_sa, rr_m1_da, rr_m1_ack, rr_m1_err;
  logic          fp_m0_sa, fp_m0_da, fp_m0_ack, fp_m0_err, fp_m1_sa, fp_m1_da, fp_m1_ack, fp_m1_err;
  logic [DW-1:0] rr_m0_q, rr_m1_q, fp_m0_q, fp_m1_q, rr_s_d, fp_s_d;
  logic [AW-1:0] rr_s_adri, fp_s_adri;
  biu_size_t     rr_s_size, fp_s_size;
  biu_type_t     rr_s_type, fp_s_type;
  biu_prot_t     rr_s_prot, fp_s_prot;
  logic          rr_s_stb, rr_s_lock, rr_s_we, rr_owner, rr_busy;
  logic          fp_s_stb, fp_s_lock, fp_s_we, fp_owner, fp_busy;
  logic [1:0]    rr_state, fp_state;

  biu_axi3_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .ARB_MODE(0)) dut_rr (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_stb_i(m0_stb), .m0_stb_ack_o(rr_m0_sa), .m0_d_ack_o(rr_m0_da), .m0_adri_i(m0_adri),
    .m0_size_i(m0_size), .m0_type_i(m0_type), .m0_prot_i(m0_prot), .m0_lock_i(m0_lock),
    .m0_we_i(m0_we), .m0_d_i(m0_d), .m0_q_o(rr_m0_q), .m0_ack_o(rr_m0_ack), .m0_err_o(rr_m0_err),
    .m1_stb_i(m1_stb), .m1_stb_ack_o(rr_m1_sa), .m1_d_ack_o(rr_m1_da), .m1_adri_i(m1_adri),
    .m1_size_i(m1_size), .m1_type_i(m1_type), .m1_prot_i(m1_prot), .m1_lock_i(m1_lock),
    .m1_we_i(m1_we), .m1_d_i(m1_d), .m1_q_o(rr_m1_q), .m1_ack_o(rr_m1_ack), .m1_err_o(rr_m1_err),
    .s_stb_o(rr_s_stb), .s_stb_ack_i(s_stb_ack), .s_d_ack_i(s_d_ack), .s_adri_o(rr_s_adri),
    .s_size_o(rr_s_size), .s_type_o(rr_s_type), .s_prot_o(rr_s_prot), .s_lock_o(rr_s_lock),
    .s_we_o(rr_s_we), .s_d_o(rr_s_d), .s_q_i(s_q), .s_ack_i(s_ack), .s_err_i(s_err),
    .arb_owner_o(rr_owner), .arb_busy_o(rr_busy), .arb_state_o(rr_state)
  );

  biu_axi3_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .ARB_MODE(1)) dut_fp (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .m0_stb_i(m0_stb), .m0_stb_ack_o(fp_m0_sa), .m0_d_ack_o(fp_m0_da), .m0_adri_i(m0_adri),
    .m0_size_i(m0_size), .m0_type_i(m0_type), .m0_prot_i(m0_prot), .m0_lock_i(m0_lock),
    .m0_we_i(m0_we), .m0_d_i(m0_d), .m0_q_o(fp_m0_q), .m0_ack_o(fp_m0_ack), .m0_err_o(fp_m0_err),
    .m1_stb_i(m1_stb), .m1_stb_ack_o(fp_m1_sa), .m1_d_ack_o(fp_m1_da), .m1_adri_i(m1_adri),
    .m1_size_i(m1_size), .m1_type_i(m1_type), .m1_prot_i(m1_prot), .m1_lock_i(m1_lock),
    .m1_we_i(m1_we), .m1_d_i(m1_d), .m1_q_o(fp_m1_q), .m1_ack_o(fp_m1_ack), .m1_err_o(fp_m1_err),
    .s_stb_o(fp_s_stb), .s_stb_ack_i(s_stb_ack), .s_d_ack_i(s_d_ack), .s_adri_o(fp_s_adri),
    .s_size_o(fp_s_size), .s_type_o(fp_s_type), .s_prot_o(fp_s_prot), .s_lock_o(fp_s_lock),
    .s_we_o(fp_s_we), .s_d_o(fp_s_d), .s_q_i(s_q), .s_ack_i(s_ack), .s_err_i(s_err),
    .arb_owner_o(fp_owner), .arb_busy_o(fp_busy), .arb_state_o(fp_state)
  );

  // {s_stb | stb_ack m0,m1 | ack m0,m1 | err m0,m1 | d_ack m0,m1 | busy | owner}
  logic [10:0] rr_obs, fp_obs;
  assign rr_obs = {rr_s_stb, rr_m0_sa, rr_m1_sa, rr_m0_ack, rr_m1_ack, rr_m0_err, rr_m1_err,
                   rr_m0_da, rr_m1_da, rr_busy, rr_owner};
  assign fp_obs = {fp_s_stb, fp_m0_sa, fp_m1_sa, fp_m0_ack, fp_m1_ack, fp_m0_err, fp_m1_err,
                   fp_m0_da, fp_m1_da, fp_busy, fp_owner};

  typedef struct {
    logic [1:0]  chk;   // 0: round-robin instance, 1: fixed-priority instance, 2: no compare
    logic        rst;
    logic [1:0]  stb;   // {m0, m1}
    logic [1:0]  lk;    // {m0, m1}
    biu_type_t   t0;
    biu_type_t   t1;
    logic [3:0]  bus;   // {s_stb_ack, s_ack, s_err, s_d_ack}
    logic [10:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  localparam biu_type_t TS = BIU_SINGLE;
  localparam biu_type_t T4 = BIU_INCR4;
  localparam biu_type_t T8 = BIU_INCR8;

  task automatic add(input logic [1:0] chk, input logic rst, input logic [1:0] stb,
                     input logic [1:0] lk, input biu_type_t t0, input biu_type_t t1,
                     input logic [3:0] bus, input logic [10:0] exp);
    vec_t v;
    v.chk = chk; v.rst = rst; v.stb = stb; v.lk = lk;
    v.t0 = t0; v.t1 = t1; v.bus = bus; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard: compare against the oldest queued expectation
  task automatic check_q(input string name, input logic [63:0] act);
    logic [63:0] e;
    e = exp_q.pop_front();
    check(name, act, e);
  endtask

  task automatic drive(input vec_t v);
    ARESETn = ~v.rst;
    m0_stb  = v.stb[1];
    m1_stb  = v.stb[0];
    m0_lock = v.lk[1];
    m1_lock = v.lk[0];
    m0_type = v.t0;
    m1_type = v.t1;
    {s_stb_ack, s_ack, s_err, s_d_ack} = v.bus;
  endtask

  task automatic next_cycle();
    @(posedge ACLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    // m0 single read: stb_ack at 2, ack at 5, idle at 6
    add(0, 0, 2'b10, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b10, 2'b00, TS, TS, 4'b0000, 11'b1_00_00_00_00_1_0);
    add(0, 0, 2'b10, 2'b00, TS, TS, 4'b1000, 11'b1_10_00_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    // round-robin from reset, then an abandoned request, then an error beat
    add(0, 1, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b1000, 11'b1_10_00_00_00_1_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b1_00_00_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b1000, 11'b1_10_00_00_00_1_0);
    add(0, 0, 2'b01, 2'b00, TS, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 0, 2'b01, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b01, 2'b00, TS, TS, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0010, 11'b0_00_00_01_00_1_1);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);
    // m1 INCR4 write with gaps between acks, m0 held off
    add(0, 0, 2'b01, 2'b00, TS, T4, 4'b0000, 11'b0_00_00_00_00_0_1);
    add(0, 0, 2'b11, 2'b00, TS, T4, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0001, 11'b0_00_00_00_01_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0000, 11'b0_00_00_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0000, 11'b0_00_00_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0000, 11'b0_00_00_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b0000, 11'b0_00_00_00_00_0_1);
    add(0, 0, 2'b10, 2'b00, TS, T4, 4'b1000, 11'b1_10_00_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, T4, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    // m1 locked single, then unlocked single; m0 requesting throughout
    add(0, 0, 2'b01, 2'b01, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b11, 2'b01, TS, TS, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(0, 0, 2'b10, 2'b01, TS, TS, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, TS, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(0, 0, 2'b10, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);
    add(0, 0, 2'b10, 2'b00, TS, TS, 4'b1000, 11'b1_10_00_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    // reset during an INCR8 data phase, stray beat afterwards, then fresh traffic
    add(0, 0, 2'b10, 2'b00, T8, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b10, 2'b00, T8, TS, 4'b1000, 11'b1_10_00_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, T8, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, T8, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 1, 2'b00, 2'b00, T8, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0100, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b11, 2'b00, TS, TS, 4'b1000, 11'b1_10_00_00_00_1_0);
    add(0, 0, 2'b01, 2'b00, TS, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(0, 0, 2'b01, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(0, 0, 2'b01, 2'b00, TS, TS, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(0, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);
    // fixed priority: m1 wins every tie, m0 only when m1 is idle
    add(2, 1, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(1, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(1, 0, 2'b11, 2'b00, TS, TS, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(1, 0, 2'b11, 2'b00, TS, TS, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(1, 0, 2'b11, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);
    add(1, 0, 2'b11, 2'b00, TS, TS, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(1, 0, 2'b10, 2'b00, TS, TS, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(1, 0, 2'b10, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);
    add(1, 0, 2'b11, 2'b00, TS, TS, 4'b1000, 11'b1_10_00_00_00_1_0);
    add(1, 0, 2'b01, 2'b00, TS, TS, 4'b0100, 11'b0_00_10_00_00_1_0);
    add(1, 0, 2'b01, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_0);
    add(1, 0, 2'b01, 2'b00, TS, TS, 4'b1000, 11'b1_01_00_00_00_1_1);
    add(1, 0, 2'b00, 2'b00, TS, TS, 4'b0100, 11'b0_00_01_00_00_1_1);
    add(1, 0, 2'b00, 2'b00, TS, TS, 4'b0000, 11'b0_00_00_00_00_0_1);

    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);

    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      drive(vecs[i]);
      @(negedge ACLK);
      if (vecs[i].chk == 2'd0) check($sformatf("row%0d_rr", i), {53'd0, rr_obs}, {53'd0, vecs[i].exp});
      else if (vecs[i].chk == 2'd1) check($sformatf("row%0d_fp", i), {53'd0, fp_obs}, {53'd0, vecs[i].exp});
    end

    // request-field forwarding and read-data broadcast on the round-robin instance
    next_cycle();
    ARESETn = 1'b0;
    {m0_stb, m1_stb, m0_lock, m1_lock, s_stb_ack, s_ack, s_err, s_d_ack} = '0;
    m0_type = BIU_SINGLE;
    m1_type = BIU_SINGLE;
    next_cycle();
    ARESETn = 1'b1;
    s_q = 32'h1234_5678;
    @(negedge ACLK);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'd0);
    exp_q.push_back(64'h1234_5678);
    exp_q.push_back(64'h1234_5678);
    check_q("reset_s_adri", {32'd0, rr_s_adri});
    check_q("reset_s_d", {32'd0, rr_s_d});
    check_q("q_bcast_m0", {32'd0, rr_m0_q});
    check_q("q_bcast_m1", {32'd0, rr_m1_q});

    next_cycle();
    m1_stb  = 1'b1;
    m1_type = BIU_INCR;
    next_cycle();
    @(negedge ACLK);
    exp_q.push_back(64'h2000_0040);
    exp_q.push_back({61'd0, BIU_INCR});
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd5);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd1);
    check_q("fwd_m1_adri", {32'd0, rr_s_adri});
    check_q("fwd_m1_type", {61'd0, rr_s_type});
    check_q("fwd_m1_size", {61'd0, rr_s_size});
    check_q("fwd_m1_prot", {61'd0, rr_s_prot});
    check_q("fwd_m1_we", {63'd0, rr_s_we});
    check_q("issue_state", {62'd0, rr_state});

    next_cycle();
    s_stb_ack = 1'b1;
    next_cycle();
    s_stb_ack = 1'b0;
    m1_stb = 1'b0;
    @(negedge ACLK);
    exp_q.push_back(64'h5050_5050);
    exp_q.push_back(64'd2);
    check_q("wait_s_d_m1", {32'd0, rr_s_d});
    check_q("wait_state", {62'd0, rr_state});

    next_cycle();
    s_ack = 1'b1;
    next_cycle();
    s_ack = 1'b0;
    m0_stb = 1'b1;
    m0_lock = 1'b1;
    next_cycle();
    @(negedge ACLK);
    exp_q.push_back(64'h1000_0010);
    exp_q.push_back(64'd1);
    exp_q.push_back(64'd0);
    check_q("fwd_m0_adri", {32'd0, rr_s_adri});
    check_q("fwd_m0_lock", {63'd0, rr_s_lock});
    check_q("fwd_m0_we", {63'd0, rr_s_we});

    next_cycle();
    m0_stb = 1'b0;
    m0_lock = 1'b0;
    ARESETn = 1'b0;
    next_cycle();
    ARESETn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
